// File: rtl/module55_value_skid.sv
// Two-entry registered skid buffer: o_valid, o_ready and o_data all come from flops,
// so there is no combinational path from i_ready back to o_ready.
//
// state   | meaning
// S_EMPTY | nothing held, o_valid=0, o_ready=1
// S_ONE   | main register holds the head value, o_valid=1, o_ready=1
// S_TWO   | main holds head, skid holds the next value, o_valid=1, o_ready=0
module module55_value_skid #(
  parameter int WIDTH     = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_data,
  output logic [CNT_WIDTH-1:0] o_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     main_q, main_nxt;
  logic [WIDTH-1:0]     skid_q, skid_nxt;
  logic                 valid_q, ready_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 in_fire, out_fire;

  assign in_fire  = i_valid & ready_q;
  assign out_fire = valid_q & i_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state)
      S_EMPTY: begin
        if (in_fire) begin
          state_nxt = S_ONE;
          main_nxt  = i_data;
        end
      end
      S_ONE: begin
        case ({in_fire, out_fire})
          2'b11: main_nxt = i_data;
          2'b10: begin
            state_nxt = S_TWO;
            skid_nxt  = i_data;
          end
          2'b01: state_nxt = S_EMPTY;
          default: state_nxt = S_ONE;
        endcase
      end
      S_TWO: begin
        // o_ready is low here, so only the drain side can move
        if (out_fire) begin
          state_nxt = S_ONE;
          main_nxt  = skid_q;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state   <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      main_q  <= main_nxt;
      skid_q  <= skid_nxt;
      // handshake flags are precomputed from the next state to stay flop-driven
      valid_q <= (state_nxt != S_EMPTY);
      ready_q <= (state_nxt != S_TWO);
      if (out_fire)
        cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign o_valid = valid_q;
  assign o_ready = ready_q;
  assign o_data  = main_q;
  assign o_count = cnt_q;

endmodule

// File: tb/tb_module55_value_skid.sv
// Bench for module55_value_skid: directed vectors, a queue-based reference model
// under random handshakes, and a narrow-counter instance for the wrap boundary.
module tb_module55_value_skid;

  logic        clk = 1'b0;
  logic        rst, valid, ready;
  logic [9:0]  data;
  logic        o_ready, o_valid;
  logic [9:0]  o_data;
  logic [15:0] o_count;

  logic        w_valid, w_ready;
  logic [9:0]  w_data;
  logic        w_o_ready, w_o_valid;
  logic [9:0]  w_o_data;
  logic [3:0]  w_o_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  module55_value_skid #(.WIDTH(10), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready), .i_data(data),
    .o_valid(o_valid), .i_ready(ready), .o_data(o_data), .o_count(o_count)
  );

  module55_value_skid #(.WIDTH(10), .CNT_WIDTH(4)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_valid(w_valid), .o_ready(w_o_ready), .i_data(w_data),
    .o_valid(w_o_valid), .i_ready(w_ready), .o_data(w_o_data), .o_count(w_o_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       v;
    logic [9:0] d;
    logic       r;
    logic       ev;
    logic       er;
    logic [9:0] ed;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[12];

  logic [9:0] q[$];
  int         cnt_m;
  bit         ifire, ofire;

  initial begin
    // rst, valid, data, ready -> expected valid, ready, data, count after the edge
    tbl[0]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h000, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 10'h3FF, 1'b0, 1'b1, 1'b1, 10'h3FF, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 10'h155, 1'b0, 1'b1, 1'b0, 10'h3FF, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 10'h0AA, 1'b0, 1'b1, 1'b0, 10'h3FF, 16'd0};
    tbl[4]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 10'h155, 16'd1};
    tbl[5]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h155, 16'd2};
    tbl[6]  = '{1'b1, 1'b1, 10'h011, 1'b0, 1'b1, 1'b1, 10'h011, 16'd2};
    tbl[7]  = '{1'b1, 1'b1, 10'h022, 1'b0, 1'b1, 1'b0, 10'h011, 16'd2};
    tbl[8]  = '{1'b0, 1'b1, 10'h033, 1'b1, 1'b0, 1'b1, 10'h000, 16'd0};
    tbl[9]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h000, 16'd0};
    tbl[10] = '{1'b1, 1'b1, 10'h2A5, 1'b1, 1'b1, 1'b1, 10'h2A5, 16'd0};
    tbl[11] = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h2A5, 16'd1};

    rst = 1'b0; valid = 1'b0; ready = 1'b0; data = '0;
    w_valid = 1'b0; w_ready = 1'b0; w_data = '0;
    tick(); tick();
    chk("reset o_valid", o_valid, 0);
    chk("reset o_ready", o_ready, 1);
    chk("reset o_count", o_count, 0);
    chk("reset o_data", o_data, 0);

    // full-rate stream, one cycle latency
    rst = 1'b1; ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      valid = 1'b1; data = 10'(i);
      tick();
      chk("stream o_valid", o_valid, 1);
      chk("stream o_data", o_data, i);
      chk("stream o_ready", o_ready, 1);
    end
    valid = 1'b0;
    tick();
    chk("stream o_count", o_count, 10);
    chk("stream drained", o_valid, 0);

    // stall, skid fill, ignored push, drain, reset in TWO
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; valid = tbl[i].v; data = tbl[i].d; ready = tbl[i].r;
      tick();
      chk($sformatf("vec%0d o_valid", i), o_valid, tbl[i].ev);
      chk($sformatf("vec%0d o_ready", i), o_ready, tbl[i].er);
      chk($sformatf("vec%0d o_data", i), o_data, tbl[i].ed);
      chk($sformatf("vec%0d o_count", i), o_count, tbl[i].ec);
    end

    // random handshakes against a FIFO model of capacity two
    rst = 1'b0; valid = 1'b0; ready = 1'b0;
    tick();
    rst = 1'b1;
    q.delete();
    cnt_m = 0;
    for (int c = 0; c < 10000; c++) begin
      valid = 1'($urandom_range(0, 1));
      ready = 1'($urandom_range(0, 1));
      data  = 10'($urandom_range(0, 1023));
      ifire = valid && (q.size() < 2);
      ofire = ready && (q.size() > 0);
      tick();
      if (ofire) begin
        void'(q.pop_front());
        cnt_m++;
      end
      if (ifire) q.push_back(data);
      chk("rand o_valid", o_valid, (q.size() > 0));
      chk("rand o_ready", o_ready, (q.size() < 2));
      if (q.size() > 0) chk("rand o_data", o_data, q[0]);
      chk("rand o_count", o_count, cnt_m & 16'hFFFF);
    end
    valid = 1'b0; ready = 1'b0;

    // counter wraps from all-ones to zero (4-bit instance)
    rst = 1'b0;
    tick();
    rst = 1'b1; w_valid = 1'b1; w_ready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      w_data = 10'(k);
      tick();
      chk($sformatf("wrap count k%0d", k), w_o_count, (k - 1) % 16);
    end
    w_valid = 1'b0; w_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
